finger_debounce: RTL and testbench

Conditions the five raw flex-sensor finger inputs before they reach the sign identification stage.
- Synchronises each finger input to clk.
- Debounces each finger independently with a consecutive-sample counter.
- Reports when the whole hand pose has been steady long enough to classify.
Outputs drive the *_status inputs of the downstream sign decoder directly; gesture_stable qualifies when that decoder's sign_value is meaningful.

---
 rtl/finger_debounce.sv | 139 +++++++++++++
 tb/tb_finger_debounce.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/finger_debounce.sv
// ============================================================================
//  Module      : finger_debounce
//  Description : Synchronises and debounces five flex-sensor finger flags and
//                flags when the hand pose has been steady long enough to use.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module finger_debounce #(
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned DB_CYCLES     = 50000,
    parameter int unsigned SETTLE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic thumb_raw,
    input  logic index_raw,
    input  logic middle_raw,
    input  logic ring_raw,
    input  logic pinky_raw,
    output logic thumb_status,
    output logic index_status,
    output logic middle_status,
    output logic ring_status,
    output logic pinky_status,
    output logic status_change,
    output logic gesture_stable
);

    localparam int unsigned           c_NUM_FINGERS = 5;
    localparam logic [CNT_W-1:0]      c_DB_LAST     = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]      c_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_SETTLING = 1'b0,
        ST_STABLE   = 1'b1
    } state_t;

    logic [c_NUM_FINGERS-1:0] w_raw;
    logic [c_NUM_FINGERS-1:0] r_sync1;
    logic [c_NUM_FINGERS-1:0] r_sync2;
    logic [c_NUM_FINGERS-1:0] w_status;
    logic [c_NUM_FINGERS-1:0] w_upd;
    logic                     w_any_upd;
    logic                     r_status_change;
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_settle_cnt;
    logic [CNT_W-1:0]         w_settle_nxt;

    assign w_raw = {pinky_raw, ring_raw, middle_raw, index_raw, thumb_raw};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // One consecutive-sample counter per finger; any agreeing sample restarts it.
    for (genvar g = 0; g < c_NUM_FINGERS; g++) begin : g_finger
        logic [CNT_W-1:0] r_cnt;
        logic             r_status;
        logic             w_differ;

        assign w_differ    = (r_sync2[g] != r_status);
        assign w_upd[g]    = w_differ && (r_cnt == c_DB_LAST);
        assign w_status[g] = r_status;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt    <= '0;
                r_status <= 1'b0;
            end else if (!w_differ) begin
                r_cnt    <= '0;
            end else if (r_cnt == c_DB_LAST) begin
                r_status <= r_sync2[g];
                r_cnt    <= '0;
            end else begin
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign w_any_upd = |w_upd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_SETTLING;
            r_settle_cnt    <= '0;
            r_status_change <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_settle_cnt    <= w_settle_nxt;
            r_status_change <= w_any_upd;
        end
    end

    // The settle count holds at its terminal value once STABLE is reached.
    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        case (r_state)
            ST_SETTLING: begin
                if (w_any_upd) begin
                    w_settle_nxt = '0;
                end else if (r_settle_cnt == c_SETTLE_LAST) begin
                    w_state_nxt  = ST_STABLE;
                end else begin
                    w_settle_nxt = r_settle_cnt + 1'b1;
                end
            end
            ST_STABLE: begin
                if (w_any_upd) begin
                    w_state_nxt  = ST_SETTLING;
                    w_settle_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = ST_SETTLING;
                w_settle_nxt = '0;
            end
        endcase
    end

    assign thumb_status   = w_status[0];
    assign index_status   = w_status[1];
    assign middle_status  = w_status[2];
    assign ring_status    = w_status[3];
    assign pinky_status   = w_status[4];
    assign status_change  = r_status_change;
    assign gesture_stable = (r_state == ST_STABLE);

endmodule

`default_nettype wire

// File: tb/tb_finger_debounce.sv
// ============================================================================
//  Module      : tb_finger_debounce
//  Description : Directed and random stimulus for finger_debounce, compared
//                against a sample-history reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_finger_debounce;

    localparam int CNT_W  = 8;
    localparam int DB     = 4;
    localparam int SETTLE = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] raw = '0;
    logic       thumb_s, index_s, middle_s, ring_s, pinky_s;
    logic       sc, gs;
    wire  [4:0] obs_status = {pinky_s, ring_s, middle_s, index_s, thumb_s};

    finger_debounce #(
        .CNT_W        (CNT_W),
        .DB_CYCLES    (DB),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .thumb_raw     (raw[0]),
        .index_raw     (raw[1]),
        .middle_raw    (raw[2]),
        .ring_raw      (raw[3]),
        .pinky_raw     (raw[4]),
        .thumb_status  (thumb_s),
        .index_status  (index_s),
        .middle_status (middle_s),
        .ring_status   (ring_s),
        .pinky_status  (pinky_s),
        .status_change (sc),
        .gesture_stable(gs)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: edges counted from reset release, raw value sampled at each edge kept.
    int         e;
    logic [4:0] samp[$];
    logic [4:0] m_status;
    int         last_flip[5];
    int         last_upd;
    logic       m_change;
    logic       m_stable;

    task automatic model_reset();
        e = 0;
        samp.delete();
        m_status = '0;
        for (int f = 0; f < 5; f++) last_flip[f] = 0;
        last_upd = 0;
        m_change = 1'b0;
        m_stable = 1'b0;
    endtask

    // Synchronised value seen at edge k is the raw value sampled two edges earlier.
    function automatic logic sync_at(int k, int f);
        logic [4:0] v;
        if (k < 3) return 1'b0;
        v = samp[k-3];
        return v[f];
    endfunction

    task automatic model_edge(input logic [4:0] r);
        logic [4:0] nxt;
        logic       upd;
        logic       all_diff;
        nxt = m_status;
        upd = 1'b0;
        e++;
        for (int f = 0; f < 5; f++) begin
            if (e - last_flip[f] >= DB) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (sync_at(e - j, f) == m_status[f]) all_diff = 1'b0;
                if (all_diff) begin
                    nxt[f]       = ~m_status[f];
                    last_flip[f] = e;
                    upd          = 1'b1;
                end
            end
        end
        m_status = nxt;
        m_change = upd;
        if (upd) last_upd = e;
        m_stable = (e - last_upd >= SETTLE);
        samp.push_back(r);
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, e, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {obs_status[4:1], obs_status[0] | sc | gs}, 5'b0);
    endtask

    task automatic step(input logic [4:0] r);
        raw = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check("status", obs_status, m_status);
        check("change", {4'b0, sc}, {4'b0, m_change});
        check("stable", {4'b0, gs}, {4'b0, m_stable});
    endtask

    int pulses;

    initial begin
        model_reset();
        // Power-up reset held for three edges
        #1 check_all_zero("reset_t0");
        repeat (3) begin
            @(posedge clk);
            #1 check_all_zero("reset_hold");
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            step(5'b00000);
            if (i == 8) check("pwr_stable_early", {4'b0, gs}, 5'b0);
            if (i == 9) check("pwr_stable_10th", {4'b0, gs}, 5'b1);
        end

        // Clean index press: first step is edge N
        for (int i = 0; i < 16; i++) begin
            step(5'b00010);
            if (i == 4)  check("press_n4", {3'b0, index_s, sc}, 5'b00);
            if (i == 5)  check("press_n5", {3'b0, index_s, sc}, 5'b11);
            if (i == 6)  check("press_n6", {3'b0, index_s, sc}, 5'b10);
            if (i == 5)  check("press_gs_fall", {4'b0, gs}, 5'b0);
            if (i == 14) check("press_gs_n14", {4'b0, gs}, 5'b0);
            if (i == 15) check("press_gs_n15", {4'b0, gs}, 5'b1);
        end
        for (int i = 0; i < 16; i++) step(5'b00000);

        // Bounce on index
        pulses = 0;
        begin
            logic [7:0] pat;
            pat = 8'b11110111;
            for (int i = 7; i >= 0; i--) begin
                step({3'b000, pat[i], 1'b0});
                if (sc) pulses++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(5'b00010);
            if (sc) pulses++;
        end
        check("bounce_pulses", 5'(pulses), 5'd1);
        for (int i = 0; i < 12; i++) step(5'b00000);

        // All fingers together
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            step(5'b11111);
            if (sc) pulses++;
        end
        check("simul_pulses", 5'(pulses), 5'd1);
        check("simul_pattern", obs_status, 5'b11111);
        for (int i = 0; i < 12; i++) step(5'b00000);

        // Reset in the middle of a thumb debounce
        for (int i = 0; i < 3; i++) step(5'b00001);
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) begin
            @(posedge clk);
            #1 check_all_zero("mid_reset_hold");
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            step(5'b00001);
            if (i == 4) check("rst_thumb_e5", {4'b0, thumb_s}, 5'b0);
            if (i == 5) check("rst_thumb_e6", {4'b0, thumb_s}, 5'b1);
        end
        for (int i = 0; i < 14; i++) step(5'b00000);

        // Staggered thumb then middle
        pulses = 0;
        step(5'b00001);
        step(5'b00001);
        for (int i = 0; i < 22; i++) begin
            step(5'b00101);
            if (sc) pulses++;
        end
        check("stagger_pulses", 5'(pulses), 5'd2);

        // Random bouncing on random fingers
        for (int i = 0; i < 800; i++) begin
            logic [4:0] r;
            int         idx;
            r = raw;
            if ($urandom_range(0, 5) == 0) begin
                idx    = int'($urandom_range(0, 4));
                r[idx] = ~r[idx];
            end
            step(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
